// File: rtl/clock_display_pkg.sv
// Shared constants and types for the clock display multiplexer: segment
// patterns (active-low {g,f,e,d,c,b,a}), ASCII codes and the scan state type.
package clock_display_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef enum logic {
      BLANK = 1'b0,
      DRIVE = 1'b1
   } scan_state_t;

   // Active-low one-hot anode enable for a slot index.
   function automatic logic [3:0] slot_anode(input logic [1:0] slot);
      return ~(4'b0001 << slot);
   endfunction

endpackage

// File: rtl/clock_display_mux_ascii_to_seg.sv
// Combinational ASCII digit to active-low 7-segment decoder; space blanks the
// digit, anything outside '0'..'9' and space shows a dash.
module ascii_to_seg
   import clock_display_pkg::*;
(
   input  logic [7:0] i_ascii,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_ascii)
         ASCII_0 + 8'd0: o_seg = SEG_0;
         ASCII_0 + 8'd1: o_seg = SEG_1;
         ASCII_0 + 8'd2: o_seg = SEG_2;
         ASCII_0 + 8'd3: o_seg = SEG_3;
         ASCII_0 + 8'd4: o_seg = SEG_4;
         ASCII_0 + 8'd5: o_seg = SEG_5;
         ASCII_0 + 8'd6: o_seg = SEG_6;
         ASCII_0 + 8'd7: o_seg = SEG_7;
         ASCII_0 + 8'd8: o_seg = SEG_8;
         ASCII_0 + 8'd9: o_seg = SEG_9;
         ASCII_SPACE:    o_seg = SEG_BLANK;
         default:        o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/clock_display_mux.sv
// Time-multiplexed 4-digit common-anode display driver with per-scan digit
// snapshot and blanking gaps. Macro CLOCK_DISPLAY_ALARM_BLINK_EN selects alarm blink.
//
// state | meaning
// BLANK | all anodes off for BLANK_CYC cycles; slot 3 BLANK captures the digits
// DRIVE | anode of r_slot on for REFRESH_DIV-BLANK_CYC cycles, then next slot
module clock_display_mux
   import clock_display_pkg::*;
#(
   parameter int REFRESH_DIV = 1024,
   parameter int BLANK_CYC   = 16,
   parameter int BLINK_DIV   = 2**20
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] ms_hour,
   input  logic [7:0] ls_hour,
   input  logic [7:0] ms_minute,
   input  logic [7:0] ls_minute,
   input  logic       alarm_sound,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - BLANK_CYC - 1);

   scan_state_t        r_state;
   scan_state_t        w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [1:0]         r_slot;
   logic [1:0]         w_slot_nxt;
   logic [3:0][7:0]    r_shadow;
   logic               w_capture;
   logic [7:0]         w_digit;
   logic [6:0]         w_seg_dec;
   logic               w_show;
   logic               w_dp_alarm;
   logic [3:0]         r_an;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic [3:0]         w_an_nxt;
   logic               w_dp_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= BLANK;
         r_cnt   <= '0;
         r_slot  <= 2'd3;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_slot  <= w_slot_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_slot_nxt  = r_slot;
      case (r_state)
         BLANK: begin
            if (r_cnt == BLANK_LAST) begin
               w_state_nxt = DRIVE;
               w_cnt_nxt   = '0;
            end
         end
         DRIVE: begin
            if (r_cnt == DRIVE_LAST) begin
               w_state_nxt = BLANK;
               w_cnt_nxt   = '0;
               w_slot_nxt  = r_slot - 2'd1;
            end
         end
         default: begin
            w_state_nxt = BLANK;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // First cycle of slot 3 BLANK; out of reset this is the very first cycle.
   assign w_capture = (r_state == BLANK) && (r_slot == 2'd3) && (r_cnt == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_shadow <= {4{ASCII_SPACE}};
      end else if (w_capture) begin
         r_shadow <= {ms_hour, ls_hour, ms_minute, ls_minute};
      end
   end

   assign w_digit = r_shadow[r_slot];

   ascii_to_seg u_ascii_to_seg (
      .i_ascii (w_digit),
      .o_seg   (w_seg_dec)
   );

`ifdef CLOCK_DISPLAY_ALARM_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_DIV + 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] r_blink_cnt;
   logic [BLINK_W-1:0] w_blink_cnt_nxt;
   logic               r_blink_on;
   logic               w_blink_on_nxt;

   always_comb begin
      w_blink_cnt_nxt = '0;
      w_blink_on_nxt  = 1'b1;
      if (alarm_sound) begin
         if (r_blink_cnt == BLINK_LAST) begin
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = ~r_blink_on;
         end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            w_blink_on_nxt  = r_blink_on;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else begin
         r_blink_cnt <= w_blink_cnt_nxt;
         r_blink_on  <= w_blink_on_nxt;
      end
   end

   // Gate with the next phase so the outputs follow the phase without lag.
   assign w_show     = w_blink_on_nxt;
   assign w_dp_alarm = 1'b0;
`else
   localparam int unused_blink_div = BLINK_DIV;

   assign w_show     = 1'b1;
   assign w_dp_alarm = alarm_sound;
`endif

   always_comb begin
      w_an_nxt = 4'hF;
      w_dp_nxt = 1'b1;
      if ((r_state == DRIVE) && w_show) begin
         w_an_nxt = slot_anode(r_slot);
         w_dp_nxt = ~((r_slot == 2'd2) | w_dp_alarm);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_an  <= 4'hF;
         r_seg <= SEG_BLANK;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= w_an_nxt;
         r_seg <= w_seg_dec;
         r_dp  <= w_dp_nxt;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;
   assign dp  = r_dp;

endmodule
